// File: rtl/tu_trigger_fifo.sv
// Trigger-word FIFO: captures non-zero words in order, registered read handshake, latest word and overflow count.
// Latency 1 cycle write->status and rd_en->rd_data/rd_valid; full buffer drops or overwrites per OVERWRITE; bitslip_ena low flushes.
module tu_trigger_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     bitslip_ena,
  input  logic [DATA_W-1:0]        trigger_data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        latest_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // The level register is the state: EMPTY, PARTIAL (anything between), FULL.
  localparam logic [LVL_W-1:0] ST_EMPTY = '0;
  localparam logic [LVL_W-1:0] ST_FULL  = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_latest;
  logic [CNT_W-1:0]  r_ovf_cnt;

  logic w_empty;
  logic w_full;
  logic w_wr_req;
  logic w_rd_acc;
  logic w_ovf;
  logic w_wr_acc;
  logic w_lvl_inc;
  logic w_lvl_dec;

  assign w_empty  = (r_level == ST_EMPTY);
  assign w_full   = (r_level == ST_FULL);
  assign w_wr_req = bitslip_ena & (|trigger_data_in);
  assign w_rd_acc = bitslip_ena & rd_en & ~w_empty;
  // A write hitting a full buffer with no read to make room is an overflow under either policy.
  assign w_ovf    = w_wr_req & w_full & ~w_rd_acc;
  assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc | (OVERWRITE != 0));
  assign w_lvl_inc = w_wr_acc & ~w_rd_acc & ~w_full;
  assign w_lvl_dec = w_rd_acc & ~w_wr_acc;

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= trigger_data_in;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= ST_EMPTY;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_latest   <= '0;
      r_ovf_cnt  <= '0;
    end else if (!bitslip_ena) begin
      // Flush keeps the overflow history; only the async reset clears it.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= ST_EMPTY;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_latest   <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_latest <= trigger_data_in;
      end
      // Overwriting the oldest entry drags the read pointer along with the write pointer.
      if (w_rd_acc || (w_wr_acc && w_ovf)) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_lvl_inc) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_lvl_dec) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_ovf && !(&r_ovf_cnt)) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign latest_out   = r_latest;
  assign empty        = w_empty;
  assign full         = w_full;
  assign level        = r_level;
  assign overflow_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_tu_trigger_fifo.sv
// Directed bench for tu_trigger_fifo: drop, overwrite and narrow-counter instances share one stimulus stream.
module tb_tu_trigger_fifo;

  logic        clk;
  logic        arst_n;
  logic        bs;
  logic [63:0] din;
  logic        rd;

  logic [63:0] d_rd_data, d_latest;
  logic        d_rd_valid, d_empty, d_full;
  logic [2:0]  d_level;
  logic [15:0] d_ovf;

  logic [63:0] o_rd_data, o_latest;
  logic        o_rd_valid, o_empty, o_full;
  logic [2:0]  o_level;
  logic [15:0] o_ovf;

  logic [63:0] s_rd_data, s_latest;
  logic        s_rd_valid, s_empty, s_full;
  logic [2:0]  s_level;
  logic [1:0]  s_ovf;

  int checks = 0;
  int errors = 0;

  tu_trigger_fifo #(.DATA_W(64), .DEPTH(4), .OVERWRITE(0), .CNT_W(16)) u_drop (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n), .bitslip_ena(bs), .trigger_data_in(din), .rd_en(rd),
    .rd_data(d_rd_data), .rd_valid(d_rd_valid), .latest_out(d_latest), .empty(d_empty),
    .full(d_full), .level(d_level), .overflow_cnt(d_ovf));

  tu_trigger_fifo #(.DATA_W(64), .DEPTH(4), .OVERWRITE(1), .CNT_W(16)) u_ovw (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n), .bitslip_ena(bs), .trigger_data_in(din), .rd_en(rd),
    .rd_data(o_rd_data), .rd_valid(o_rd_valid), .latest_out(o_latest), .empty(o_empty),
    .full(o_full), .level(o_level), .overflow_cnt(o_ovf));

  tu_trigger_fifo #(.DATA_W(64), .DEPTH(4), .OVERWRITE(0), .CNT_W(2)) u_sat (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n), .bitslip_ena(bs), .trigger_data_in(din), .rd_en(rd),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .latest_out(s_latest), .empty(s_empty),
    .full(s_full), .level(s_level), .overflow_cnt(s_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        bs;
    logic [63:0] din;
    logic        rd;
    logic [2:0]  lvl;
    logic        rv;
    logic [63:0] rdat;
    logic [63:0] lat;
    logic [15:0] ovf;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic [63:0] d, input logic r);
    bs  = b;
    din = d;
    rd  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_drop_zero(input string tag);
    chk({tag, " level"},    64'(d_level), 64'd0);
    chk({tag, " empty"},    64'(d_empty), 64'd1);
    chk({tag, " full"},     64'(d_full), 64'd0);
    chk({tag, " rd_valid"}, 64'(d_rd_valid), 64'd0);
    chk({tag, " rd_data"},  d_rd_data, 64'd0);
    chk({tag, " latest"},   d_latest, 64'd0);
    chk({tag, " ovf"},      64'(d_ovf), 64'd0);
  endtask

  // Reset pulse placed between edges so the async clear is observed without a clock.
  task automatic mid_reset(input string tag);
    #2 arst_n = 1'b0;
    #1;
    check_drop_zero(tag);
    chk({tag, " ovw ovf"}, 64'(o_ovf), 64'd0);
    chk({tag, " sat ovf"}, 64'(s_ovf), 64'd0);
    arst_n = 1'b1;
  endtask

  initial begin
    //          bs    din      rd    lvl   rv    rdat     lat      ovf
    vecs[0]  = '{1'b1, 64'h11, 1'b0, 3'd1, 1'b0, 64'h00, 64'h11, 16'd0};
    vecs[1]  = '{1'b1, 64'h00, 1'b0, 3'd1, 1'b0, 64'h00, 64'h11, 16'd0};
    vecs[2]  = '{1'b1, 64'h22, 1'b0, 3'd2, 1'b0, 64'h00, 64'h22, 16'd0};
    vecs[3]  = '{1'b1, 64'h33, 1'b0, 3'd3, 1'b0, 64'h00, 64'h33, 16'd0};
    vecs[4]  = '{1'b1, 64'h00, 1'b1, 3'd2, 1'b1, 64'h11, 64'h33, 16'd0};
    vecs[5]  = '{1'b1, 64'h00, 1'b1, 3'd1, 1'b1, 64'h22, 64'h33, 16'd0};
    vecs[6]  = '{1'b1, 64'h00, 1'b1, 3'd0, 1'b1, 64'h33, 64'h33, 16'd0};
    vecs[7]  = '{1'b1, 64'h00, 1'b1, 3'd0, 1'b0, 64'h33, 64'h33, 16'd0};
    vecs[8]  = '{1'b1, 64'h01, 1'b0, 3'd1, 1'b0, 64'h33, 64'h01, 16'd0};
    vecs[9]  = '{1'b1, 64'h02, 1'b0, 3'd2, 1'b0, 64'h33, 64'h02, 16'd0};
    vecs[10] = '{1'b1, 64'h03, 1'b0, 3'd3, 1'b0, 64'h33, 64'h03, 16'd0};
    vecs[11] = '{1'b1, 64'h04, 1'b0, 3'd4, 1'b0, 64'h33, 64'h04, 16'd0};
    vecs[12] = '{1'b1, 64'h05, 1'b0, 3'd4, 1'b0, 64'h33, 64'h04, 16'd1};
    vecs[13] = '{1'b1, 64'h06, 1'b0, 3'd4, 1'b0, 64'h33, 64'h04, 16'd2};
    vecs[14] = '{1'b1, 64'h07, 1'b1, 3'd4, 1'b1, 64'h01, 64'h07, 16'd2};
    vecs[15] = '{1'b1, 64'h00, 1'b1, 3'd3, 1'b1, 64'h02, 64'h07, 16'd2};
    vecs[16] = '{1'b1, 64'h00, 1'b1, 3'd2, 1'b1, 64'h03, 64'h07, 16'd2};
    vecs[17] = '{1'b1, 64'h00, 1'b1, 3'd1, 1'b1, 64'h04, 64'h07, 16'd2};
    vecs[18] = '{1'b1, 64'h00, 1'b1, 3'd0, 1'b1, 64'h07, 64'h07, 16'd2};
    vecs[19] = '{1'b1, 64'h09, 1'b1, 3'd1, 1'b0, 64'h07, 64'h09, 16'd2};
    vecs[20] = '{1'b1, 64'h0A, 1'b0, 3'd2, 1'b0, 64'h07, 64'h0A, 16'd2};
    vecs[21] = '{1'b1, 64'h0B, 1'b0, 3'd3, 1'b0, 64'h07, 64'h0B, 16'd2};
    vecs[22] = '{1'b0, 64'h55, 1'b1, 3'd0, 1'b0, 64'h00, 64'h00, 16'd2};
    vecs[23] = '{1'b1, 64'h00, 1'b1, 3'd0, 1'b0, 64'h00, 64'h00, 16'd2};
    vecs[24] = '{1'b1, 64'h0C, 1'b0, 3'd1, 1'b0, 64'h00, 64'h0C, 16'd2};

    arst_n = 1'b0;
    bs     = 1'b1;
    din    = '0;
    rd     = 1'b0;
    #2;
    check_drop_zero("por");
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].bs, vecs[i].din, vecs[i].rd);
      chk($sformatf("v%0d level", i),    64'(d_level), 64'(vecs[i].lvl));
      chk($sformatf("v%0d empty", i),    64'(d_empty), 64'(vecs[i].lvl == 3'd0));
      chk($sformatf("v%0d full", i),     64'(d_full), 64'(vecs[i].lvl == 3'd4));
      chk($sformatf("v%0d rd_valid", i), 64'(d_rd_valid), 64'(vecs[i].rv));
      chk($sformatf("v%0d rd_data", i),  d_rd_data, vecs[i].rdat);
      chk($sformatf("v%0d latest", i),   d_latest, vecs[i].lat);
      chk($sformatf("v%0d ovf", i),      64'(d_ovf), 64'(vecs[i].ovf));
    end

    mid_reset("rst_mid");

    // Drop vs overwrite: the same six writes into a 4-deep buffer.
    for (int i = 1; i <= 6; i++) step(1'b1, 64'(i), 1'b0);
    chk("ovw level", 64'(o_level), 64'd4);
    chk("ovw full",  64'(o_full), 64'd1);
    chk("ovw ovf",   64'(o_ovf), 64'd2);
    chk("ovw latest", o_latest, 64'h6);
    chk("drop full", 64'(d_full), 64'd1);
    chk("drop ovf",  64'(d_ovf), 64'd2);
    chk("drop latest", d_latest, 64'h4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 64'h0, 1'b1);
      chk($sformatf("ovw rd%0d valid", i), 64'(o_rd_valid), 64'd1);
      chk($sformatf("ovw rd%0d data", i),  o_rd_data, 64'(i + 3));
      chk($sformatf("drop rd%0d valid", i), 64'(d_rd_valid), 64'd1);
      chk($sformatf("drop rd%0d data", i),  d_rd_data, 64'(i + 1));
    end
    step(1'b1, 64'h0, 1'b0);
    chk("ovw pulse end", 64'(o_rd_valid), 64'd0);
    chk("ovw empty", 64'(o_empty), 64'd1);
    chk("drop pulse end", 64'(d_rd_valid), 64'd0);
    chk("ovw hold data", o_rd_data, 64'h6);

    mid_reset("rst_sat");

    // 2-bit counter: 4 fills, then 5 dropped writes must stick at 3.
    for (int i = 1; i <= 7; i++) step(1'b1, 64'(i + 16), 1'b0);
    chk("sat ovf at 3", 64'(s_ovf), 64'd3);
    step(1'b1, 64'h21, 1'b0);
    step(1'b1, 64'h22, 1'b0);
    chk("sat ovf hold", 64'(s_ovf), 64'd3);
    chk("sat level", 64'(s_level), 64'd4);
    chk("sat latest", s_latest, 64'h14);
    chk("ovw ovf grows", 64'(o_ovf), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
